// File: rtl/pc_fetch_unit_pkg.sv
// Shared types and defaults for the IF-stage program counter block.
package pc_fetch_unit_pkg;

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } fetch_state_e;

    localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] DEF_PC_STEP      = 32'd4;

    // Instruction fetches are always word aligned; low address bits are dropped.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Control inputs and fetch outputs of the PC fetch unit.
interface pc_fetch_unit_if;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt_req;
    logic [31:0] mem_addr;
    logic [31:0] pc;
    logic [31:0] if_pc;
    logic        if_valid;
    logic        misaligned;

    modport master (
        output stall, redirect_valid, redirect_pc, halt_req,
        input  mem_addr, pc, if_pc, if_valid, misaligned
    );

    modport slave (
        input  stall, redirect_valid, redirect_pc, halt_req,
        output mem_addr, pc, if_pc, if_valid, misaligned
    );
endinterface

// File: rtl/pc_fetch_unit.sv
// Program counter, fetch-address mux and read-port tracking for a
// synchronous-read instruction memory with one cycle of latency.
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = DEF_RESET_VECTOR,
    parameter logic [31:0] PC_STEP      = DEF_PC_STEP
) (
    input  logic            clk,
    input  logic            rst,
    pc_fetch_unit_if.slave  bus
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  if_pc_q, if_pc_d;
    logic         if_valid_q, if_valid_d;
    logic         mis_q, mis_d;
    logic [31:0]  mem_addr;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_BOOT;
            pc_q       <= RESET_VECTOR;
            if_pc_q    <= RESET_VECTOR;
            if_valid_q <= 1'b0;
            mis_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            if_pc_q    <= if_pc_d;
            if_valid_q <= if_valid_d;
            mis_q      <= mis_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        if_pc_d    = if_pc_q;
        if_valid_d = if_valid_q;
        mis_d      = 1'b0;
        mem_addr   = pc_q;
        unique case (state_q)
            S_BOOT: begin
                state_d    = S_RUN;
                pc_d       = pc_q + PC_STEP;
                if_pc_d    = pc_q;
                if_valid_d = 1'b1;
            end
            S_RUN: begin
                // EX redirect is older than anything ID asks for, so it wins.
                if (bus.redirect_valid) begin
                    pc_d       = word_align(bus.redirect_pc);
                    if_pc_d    = pc_q;
                    if_valid_d = 1'b0;
                    mis_d      = |bus.redirect_pc[1:0];
                end else if (bus.stall) begin
                    mem_addr = if_pc_q;
                end else if (bus.halt_req) begin
                    state_d    = S_HALT;
                    if_valid_d = 1'b0;
                end else begin
                    pc_d       = pc_q + PC_STEP;
                    if_pc_d    = pc_q;
                    if_valid_d = 1'b1;
                end
            end
            default: begin
                state_d    = S_HALT;
                if_valid_d = 1'b0;
            end
        endcase
    end

    assign bus.mem_addr   = mem_addr;
    assign bus.pc         = pc_q;
    assign bus.if_pc      = if_pc_q;
    assign bus.if_valid   = if_valid_q;
    assign bus.misaligned = mis_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: per-cycle expected outputs are queued by
// the stimulus and compared by negedge monitors.
module tb_pc_fetch_unit;

    typedef struct packed {
        logic [31:0] mem;
        logic [31:0] pc;
        logic [31:0] ifpc;
        logic        v;
        logic        mis;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pc_fetch_unit_if ua ();
    pc_fetch_unit_if ub ();

    pc_fetch_unit #(.RESET_VECTOR(32'h0000_0000), .PC_STEP(32'd4)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ua.slave)
    );

    pc_fetch_unit #(.RESET_VECTOR(32'hFFFF_FFF8), .PC_STEP(32'd4)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ub.slave)
    );

    exp_t qa[$];
    exp_t qb[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc_no   = 0;

    task automatic chk(input string name, input int cyc, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endtask

    task automatic cmp(input string tag, input int cyc, input exp_t e,
                       input logic [31:0] mem, input logic [31:0] pc, input logic [31:0] ifpc,
                       input logic v, input logic mis);
        chk({tag, ".mem_addr"},   cyc, mem,          e.mem);
        chk({tag, ".pc"},         cyc, pc,           e.pc);
        chk({tag, ".if_pc"},      cyc, ifpc,         e.ifpc);
        chk({tag, ".if_valid"},   cyc, {31'd0, v},   {31'd0, e.v});
        chk({tag, ".misaligned"}, cyc, {31'd0, mis}, {31'd0, e.mis});
    endtask

    always @(negedge clk) begin
        if (qa.size() != 0) begin
            exp_t e;
            e = qa.pop_front();
            cmp("A", cyc_no, e, ua.mem_addr, ua.pc, ua.if_pc, ua.if_valid, ua.misaligned);
        end
    end

    always @(negedge clk) begin
        if (qb.size() != 0) begin
            exp_t e;
            e = qb.pop_front();
            cmp("B", cyc_no, e, ub.mem_addr, ub.pc, ub.if_pc, ub.if_valid, ub.misaligned);
        end
    end

    // One cycle of stimulus on DUT A plus the outputs expected before the next edge.
    task automatic cyc(input logic r, input logic s, input logic rv, input logic [31:0] rpc,
                       input logic h, input logic [31:0] mem, input logic [31:0] pc,
                       input logic [31:0] ifpc, input logic v, input logic mis);
        exp_t e;
        @(posedge clk);
        #1;
        cyc_no++;
        rst               = r;
        ua.stall          = s;
        ua.redirect_valid = rv;
        ua.redirect_pc    = rpc;
        ua.halt_req       = h;
        e.mem = mem; e.pc = pc; e.ifpc = ifpc; e.v = v; e.mis = mis;
        qa.push_back(e);
    endtask

    task automatic push_b(input logic [31:0] mem, input logic [31:0] pc,
                          input logic [31:0] ifpc, input logic v);
        exp_t e;
        e.mem = mem; e.pc = pc; e.ifpc = ifpc; e.v = v; e.mis = 1'b0;
        qb.push_back(e);
    endtask

    initial begin
        ua.stall = 0; ua.redirect_valid = 0; ua.redirect_pc = 0; ua.halt_req = 0;
        ub.stall = 0; ub.redirect_valid = 0; ub.redirect_pc = 0; ub.halt_req = 0;

        // reset held two cycles, then boot and sequential fetch
        //  r  s  rv rpc          h  mem          pc           ifpc         v  mis
        cyc(1, 0, 0, 32'h0,       0, 32'h0,       32'h0,       32'h0,       0, 0); push_b(32'hFFFF_FFF8, 32'hFFFF_FFF8, 32'hFFFF_FFF8, 0);
        cyc(0, 0, 0, 32'h0,       0, 32'h0,       32'h0,       32'h0,       0, 0); push_b(32'hFFFF_FFF8, 32'hFFFF_FFF8, 32'hFFFF_FFF8, 0);
        cyc(0, 0, 0, 32'h0,       0, 32'h4,       32'h4,       32'h0,       1, 0); push_b(32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'hFFFF_FFF8, 1);
        cyc(0, 0, 0, 32'h0,       0, 32'h8,       32'h8,       32'h4,       1, 0); push_b(32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFC, 1);
        cyc(0, 0, 0, 32'h0,       0, 32'hC,       32'hC,       32'h8,       1, 0); push_b(32'h0000_0004, 32'h0000_0004, 32'h0000_0000, 1);
        // stall replay of 0x0C for three cycles
        cyc(0, 1, 0, 32'h0,       0, 32'hC,       32'h10,      32'hC,       1, 0); push_b(32'h0000_0008, 32'h0000_0008, 32'h0000_0004, 1);
        cyc(0, 1, 0, 32'h0,       0, 32'hC,       32'h10,      32'hC,       1, 0);
        cyc(0, 1, 0, 32'h0,       0, 32'hC,       32'h10,      32'hC,       1, 0);
        cyc(0, 0, 0, 32'h0,       0, 32'h10,      32'h10,      32'hC,       1, 0);
        cyc(0, 0, 0, 32'h0,       0, 32'h14,      32'h14,      32'h10,      1, 0);
        cyc(0, 0, 0, 32'h0,       0, 32'h18,      32'h18,      32'h14,      1, 0);
        cyc(0, 0, 0, 32'h0,       0, 32'h1C,      32'h1C,      32'h18,      1, 0);
        // aligned redirect to 0x100 from pc=0x20
        cyc(0, 0, 1, 32'h100,     0, 32'h20,      32'h20,      32'h1C,      1, 0);
        cyc(0, 0, 0, 32'h0,       0, 32'h100,     32'h100,     32'h20,      0, 0);
        cyc(0, 0, 0, 32'h0,       0, 32'h104,     32'h104,     32'h100,     1, 0);
        // misaligned redirect beating stall and halt in the same cycle
        cyc(0, 1, 1, 32'h102,     1, 32'h108,     32'h108,     32'h104,     1, 0);
        cyc(0, 0, 0, 32'h0,       0, 32'h100,     32'h100,     32'h108,     0, 1);
        cyc(0, 0, 0, 32'h0,       0, 32'h104,     32'h104,     32'h100,     1, 0);
        // redirect to 0x40, stall in the bubble, then halt
        cyc(0, 0, 1, 32'h40,      0, 32'h108,     32'h108,     32'h104,     1, 0);
        cyc(0, 1, 0, 32'h0,       0, 32'h108,     32'h40,      32'h108,     0, 0);
        cyc(0, 0, 0, 32'h0,       1, 32'h40,      32'h40,      32'h108,     0, 0);
        // halted: redirect, stall and halt all ignored
        cyc(0, 0, 1, 32'h200,     0, 32'h40,      32'h40,      32'h108,     0, 0);
        cyc(0, 1, 0, 32'h0,       1, 32'h40,      32'h40,      32'h108,     0, 0);
        cyc(0, 0, 0, 32'h0,       0, 32'h40,      32'h40,      32'h108,     0, 0);
        // reset out of halt
        cyc(1, 0, 0, 32'h0,       0, 32'h40,      32'h40,      32'h108,     0, 0);
        cyc(0, 0, 0, 32'h0,       0, 32'h0,       32'h0,       32'h0,       0, 0);
        cyc(0, 0, 0, 32'h0,       0, 32'h4,       32'h4,       32'h0,       1, 0);

        repeat (2) @(posedge clk);
        checks++;
        if (qa.size() != 0 || qb.size() != 0) begin
            failures++;
            $display("FAIL drain got=%0d/%0d want=0/0", qa.size(), qb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
